cmd_framer: RTL
===============

# cmd_framer

Command-frame serializer for the key-value command link: accepts one command (opcode, key, value), packs it into a five-byte frame with an XOR checksum, and drives it onto the serial line as start/data/stop-framed bytes paced by the shared `ticker` baud strobe. It is the sending end of the link whose receiving end is the command extractor. It replaces the per-byte `read_enable`/`bus_value` sequencing that testbenches currently do by hand.

## Interface
- `VAL_BYTES`, 2: value width in bytes. The frame carries them MSB first.
- `SYNC_STAGES`, 2: synchronizer depth for `ticker`. Minimum 2.

- `clock` in 1: system clock. All state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ticker` in 1: baud strobe, a free-running square wave asynchronous to `clock`. One bit time is the interval from one rising edge to the next.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_opcode` in 8: opcode byte.
- `cmd_key` in 8: key byte.
- `cmd_value` in 8*VAL_BYTES: value.
- `signal` out 1: serial line. Idle high.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-clock pulse when the final stop bit completes.

## Operation
- Frame byte order: opcode, key, value bytes MSB→LSB, checksum.
- Checksum is the XOR of all preceding frame bytes.
- Frame length is 3+VAL_BYTES bytes; 5 at the default.
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Back-to-back bytes within a frame have no idle gap.
- Handshake: a command is accepted on a clock edge where `cmd_valid && cmd_ready`.
  - Opcode, key and value are latched on that edge; inputs may change afterwards.
  - The checksum is computed from the latched copy.
- `cmd_ready` is high only in IDLE.
- State machine:
  - IDLE: `signal`=1. Acceptance → ALIGN.
  - ALIGN: wait for the next synchronized `ticker` rising edge (tick) → START.
  - START: `signal`=0 for one bit time. Next tick → DATA, bit_cnt=0.
  - DATA: `signal`=shift[0]. Each tick shifts right and increments bit_cnt. Tick at bit_cnt=7 → STOP.
  - STOP: `signal`=1.
    - Tick with byte_idx < last: byte_idx+1, load the next byte → START.
    - Tick with byte_idx = last: pulse `frame_done` → IDLE.
- `busy` = state ≠ IDLE.
- Counters: bit_cnt 3 bits; byte_idx is wide enough for 3+VAL_BYTES. Neither counter wraps; both are cleared when a frame is accepted.
- `cmd_valid` held high across frames: the next frame is accepted in the first IDLE cycle after `frame_done`. This gives exactly one stop bit plus ALIGN wait between frames.
- Reset, including mid-frame, takes effect immediately:
  - `signal`=1, state IDLE, counters 0, `frame_done`=0.
  - A partial frame is abandoned, not resumed.

## Timing
- Reset values: `signal`=1, `cmd_ready`=1 (after reset release), `busy`=0, `frame_done`=0.
- Tick detect latency: SYNC_STAGES+1 clocks after the `ticker` rising edge. All bit boundaries carry this same fixed offset, so every bit is exactly one ticker period long.
- `signal` is a registered output. It changes on the clock edge where the tick is detected.
- Start bit begins at the first tick strictly after acceptance. Acceptance and tick in the same cycle: that tick is not used.
- `frame_done` is asserted in the same cycle `signal` leaves the last stop bit. `cmd_ready` rises in the same cycle.
- Frame duration from first start edge to `frame_done`: (3+VAL_BYTES)*10 ticker periods.
- `cmd_valid` without `cmd_ready` has no effect and is not queued.

## Structure
- Package `cmd_pkg`:
  - opcode constants (`OP_SET`=3, `OP_GET`=4, `OP_DEL`=5)
  - `BITS_PER_BYTE`=8
  - state enum
  - frame-length function of VAL_BYTES
- Sub-module `tick_edge`: SYNC_STAGES-flop synchronizer on `ticker` plus rising-edge detector producing a one-clock `tick` pulse. Resets to 0 with `rst_n`.

## Test plan
- Reset then idle for 5 ticker periods → `signal` stays 1, `cmd_ready`=1, `busy`=0, no `frame_done`.
- Command opcode=3, key=45, value=0x0943:
  - line carries bytes 3, 45, 9, 67, 100 (checksum 0x64);
  - byte 3 appears as 0,1,1,0,0,0,0,0,0,1;
  - each bit lasts one ticker period (400 ps at the bench's 200 ps half-period);
  - `frame_done` pulses once after 50 periods.
- `cmd_valid` held high with two commands (3/45/0x0943, then 5/7/0x0000):
  - second frame starts at the first tick after the first `frame_done`;
  - second checksum is 2.
- Inputs changed the cycle after acceptance → transmitted bytes match the latched values.
- `rst_n` pulsed low during key byte bit 4 → `signal`=1 immediately, `busy`=0. A new command afterwards sends a complete, correct frame.
- `cmd_valid` asserted in the same cycle as a tick → start bit begins at the following tick, not that one.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared constants, FSM states and frame sizing for the command-frame link.
package cmd_pkg;

  localparam logic [7:0] OP_SET = 8'd3;
  localparam logic [7:0] OP_GET = 8'd4;
  localparam logic [7:0] OP_DEL = 8'd5;

  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  function automatic int frame_len(input int val_bytes);
    return 3 + val_bytes;
  endfunction

endpackage

// File: rtl/tick_edge.sv
// Synchronizes the asynchronous baud square wave and emits a one-clock
// pulse on each of its rising edges.
module tick_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic rst_n,
  input  logic ticker_i,
  output logic tick_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ticker_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/cmd_framer.sv
// Serializes one opcode/key/value command into a checksummed UART-style
// frame, paced by the shared baud strobe.
module cmd_framer
  import cmd_pkg::*;
#(
  parameter int VAL_BYTES   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   ticker,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_opcode,
  input  logic [7:0]             cmd_key,
  input  logic [8*VAL_BYTES-1:0] cmd_value,
  output logic                   signal,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int FLEN = frame_len(VAL_BYTES);
  localparam int NLAT = FLEN - 1;
  localparam int IW   = $clog2(FLEN + 1);
  localparam logic [IW-1:0] LAST = IW'(FLEN - 1);
  localparam logic [2:0] BIT_LAST = 3'(BITS_PER_BYTE - 1);

  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]          byte_idx_q, byte_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   signal_q, signal_d;
  logic                   done_q, done_d;
  logic [NLAT-1:0][7:0]   lat_q, lat_d;
  logic [FLEN-1:0][7:0]   frame_b;
  logic [7:0]             csum;
  logic                   tick;

  tick_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick (
    .clock   (clock),
    .rst_n   (rst_n),
    .ticker_i(ticker),
    .tick_o  (tick)
  );

  // Checksum always derives from the latched copy, never the live inputs
  always_comb begin
    csum = '0;
    for (int i = 0; i < NLAT; i++) csum = csum ^ lat_q[i];
    frame_b = {csum, lat_q};
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    signal_d   = signal_q;
    done_d     = 1'b0;
    lat_d      = lat_q;
    unique case (state_q)
      ST_IDLE: begin
        signal_d = 1'b1;
        if (cmd_valid) begin
          state_d    = ST_ALIGN;
          bit_cnt_d  = '0;
          byte_idx_d = '0;
          lat_d[0]   = cmd_opcode;
          lat_d[1]   = cmd_key;
          for (int i = 0; i < VAL_BYTES; i++)
            lat_d[2+i] = cmd_value[8*(VAL_BYTES-1-i) +: 8];
        end
      end
      ST_ALIGN: begin
        if (tick) begin
          state_d  = ST_START;
          signal_d = 1'b0;
          shift_d  = frame_b[0];
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          signal_d  = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d  = ST_STOP;
            signal_d = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
            signal_d  = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (byte_idx_q == LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_START;
            byte_idx_d = byte_idx_q + 1'b1;
            shift_d    = frame_b[byte_idx_q + 1'b1];
            signal_d   = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      signal_q   <= 1'b1;
      done_q     <= 1'b0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      signal_q   <= signal_d;
      done_q     <= done_d;
      lat_q      <= lat_d;
    end
  end

  assign signal     = signal_q;
  assign busy       = (state_q != ST_IDLE);
  assign cmd_ready  = (state_q == ST_IDLE);
  assign frame_done = done_q;

endmodule
